// File: rtl/wb_stage_if.sv
// wb_stage_if: bundles the MEM-side inputs and the register-heap / forwarding
// outputs of the writeback stage. The master modport is the upstream pipeline
// together with the heap and forwarding consumers. The slave modport is the stage.
//
// Handshake: in_valid qualifies in_reg_write/in_mem_to_reg/in_dest/in_alu_result/
// in_mem_data and is sampled only on a rising edge where stall=0 and flush=0.
// stall is the only back-pressure, and flush beats stall.
// EN_WRITE_REG=0 means the heap writes w_reg/w_data on the next falling edge.
// fwd_valid qualifies fwd_reg/fwd_data.
interface wb_stage_if #(
    parameter int REG_WIDTH = 4
);
    logic                 stall;
    logic                 flush;
    logic                 in_valid;
    logic                 in_reg_write;
    logic                 in_mem_to_reg;
    logic [REG_WIDTH-1:0] in_dest;
    logic [15:0]          in_alu_result;
    logic [15:0]          in_mem_data;

    logic                 EN_WRITE_REG;
    logic [REG_WIDTH-1:0] w_reg;
    logic [15:0]          w_data;
    logic                 fwd_valid;
    logic [REG_WIDTH-1:0] fwd_reg;
    logic [15:0]          fwd_data;

    modport master (
        output stall, flush, in_valid, in_reg_write, in_mem_to_reg,
               in_dest, in_alu_result, in_mem_data,
        input  EN_WRITE_REG, w_reg, w_data, fwd_valid, fwd_reg, fwd_data
    );

    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_mem_to_reg,
               in_dest, in_alu_result, in_mem_data,
        output EN_WRITE_REG, w_reg, w_data, fwd_valid, fwd_reg, fwd_data
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register plus writeback mux for the 16-bit core.
// The stage loads on the rising edge of CLK. The register heap writes on the
// following falling edge, so the heap sees a stable write port for half a cycle.
// A stalled instruction is written only once. The done flag marks it as already
// retired, but it stays visible on the forwarding port.
// Optional build macro WB_RETIRE_CNT_EN adds the 16-bit retire_cnt output.
// retire_cnt counts the writes actually issued to the heap.
module wb_stage #(
    parameter int REG_WIDTH  = 4,
    parameter bit PROTECT_R0 = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    wb_stage_if.slave    bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [15:0]  retire_cnt
`endif
);

    logic                 valid_q, valid_d;
    logic                 reg_write_q, reg_write_d;
    logic [REG_WIDTH-1:0] dest_q, dest_d;
    logic [15:0]          data_q, data_d;
    logic                 done_q, done_d;

    logic [15:0]          mux_data;
    logic                 r0_blocked;
    logic                 wr;

    // Writeback source select, ahead of the register for single-cycle latency.
    always_comb begin
        mux_data = bus.in_mem_to_reg ? bus.in_mem_data : bus.in_alu_result;
    end

    // Next-state: flush beats stall, and stall beats load.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        dest_d      = dest_q;
        data_d      = data_q;
        done_d      = done_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else if (bus.stall) begin
            done_d = valid_q & reg_write_q;
        end else begin
            valid_d     = bus.in_valid;
            reg_write_d = bus.in_reg_write;
            dest_d      = bus.in_dest;
            data_d      = mux_data;
            done_d      = 1'b0;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            dest_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            dest_q      <= dest_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

    // Heap write port and forwarding view, derived from the held state.
    // RST masks the write enable directly, so no heap write can slip in while
    // reset is asserted.
    always_comb begin
        r0_blocked       = PROTECT_R0 && (dest_q == '0);
        wr               = valid_q & reg_write_q & ~done_q & ~r0_blocked & ~RST;
        bus.EN_WRITE_REG = ~wr;
        bus.w_reg        = dest_q;
        bus.w_data       = data_q;
        bus.fwd_valid    = valid_q & reg_write_q & ~r0_blocked & ~RST;
        bus.fwd_reg      = dest_q;
        bus.fwd_data     = data_q;
    end

`ifdef WB_RETIRE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Retire count advances on every edge that closes a cycle with a heap write.
    always_comb begin
        cnt_d = cnt_q + {15'd0, wr};
    end

    // Retire counter register; it wraps naturally at 16 bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized and directed stimulus for wb_stage.
// A scoreboard queue holds the heap writes expected from each accepted instruction.
// A negedge monitor compares the DUT's write port and forwarding view against it.
// The main DUT protects r0. A second DUT without that protection shares the same
// inputs.
module tb_wb_stage;

    localparam int RW = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    wb_stage_if #(.REG_WIDTH(RW)) bus  ();
    wb_stage_if #(.REG_WIDTH(RW)) bus0 ();

    assign bus0.stall         = bus.stall;
    assign bus0.flush         = bus.flush;
    assign bus0.in_valid      = bus.in_valid;
    assign bus0.in_reg_write  = bus.in_reg_write;
    assign bus0.in_mem_to_reg = bus.in_mem_to_reg;
    assign bus0.in_dest       = bus.in_dest;
    assign bus0.in_alu_result = bus.in_alu_result;
    assign bus0.in_mem_data   = bus.in_mem_data;

`ifdef WB_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
    logic [15:0] retire_cnt0;
`endif

    wb_stage #(.REG_WIDTH(RW), .PROTECT_R0(1'b1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    wb_stage #(.REG_WIDTH(RW), .PROTECT_R0(1'b0)) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt0)
`endif
    );

    // Scoreboard state and reference model
    logic [RW+15:0] exp_q[$];
    int             errors = 0;
    int             checks = 0;
    int             writes_seen = 0;
    bit             held_writer = 1'b0;
    logic [RW-1:0]  held_dest = '0;
    logic [15:0]    held_data = '0;
    logic [15:0]    heap  [16];
    logic [15:0]    heap0 [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Applies one cycle of inputs. After the rising edge, the model updates the
    // instruction held in the stage. A newly loaded writer must produce exactly one
    // heap write.
    task automatic drive(input bit v, input bit rw, input bit m2r, input logic [RW-1:0] d,
                         input logic [15:0] alu, input logic [15:0] mem,
                         input bit st, input bit fl);
        bus.in_valid      = v;
        bus.in_reg_write  = rw;
        bus.in_mem_to_reg = m2r;
        bus.in_dest       = d;
        bus.in_alu_result = alu;
        bus.in_mem_data   = mem;
        bus.stall         = st;
        bus.flush         = fl;
        @(posedge CLK);
        if (fl) begin
            held_writer = 1'b0;
        end else if (!st) begin
            held_writer = v && rw && (d != 0);
            held_dest   = d;
            held_data   = m2r ? mem : alu;
            if (held_writer) exp_q.push_back({d, held_data});
        end
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    // Register heaps: write on the falling edge whenever the write enable is low.
    always @(negedge CLK) begin
        if (bus.EN_WRITE_REG === 1'b0) heap[bus.w_reg] = bus.w_data;
        if (bus0.EN_WRITE_REG === 1'b0) heap0[bus0.w_reg] = bus0.w_data;
    end

    // Monitor: check the forwarding view, then match any heap write against the queue.
    always @(negedge CLK) begin
        logic [RW+15:0] e;
        if (RST === 1'b0) begin
            chk("fwd_valid", 32'(bus.fwd_valid), 32'(held_writer));
            if (held_writer) begin
                chk("fwd_reg", 32'(bus.fwd_reg), 32'(held_dest));
                chk("fwd_data", 32'(bus.fwd_data), 32'(held_data));
            end
`ifdef WB_RETIRE_CNT_EN
            chk("retire_cnt", 32'(retire_cnt), 32'(writes_seen[15:0]));
`endif
            if (bus.EN_WRITE_REG === 1'b0) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got reg %h data %h expected no write at %0t",
                             bus.w_reg, bus.w_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_port", 32'({bus.w_reg, bus.w_data}), 32'(e));
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_write: got no write expected reg/data %h at %0t", e, $time);
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            heap[i]  = 16'h0;
            heap0[i] = 16'h0;
        end
        RST = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_reg_write = 1'b0;
        bus.in_mem_to_reg = 1'b0; bus.in_dest = '0; bus.in_alu_result = '0; bus.in_mem_data = '0;
        #2;
        chk("rst_en_write", 32'(bus.EN_WRITE_REG), 32'd1);
        chk("rst_w_reg", 32'(bus.w_reg), 32'd0);
        chk("rst_w_data", 32'(bus.w_data), 32'd0);
        chk("rst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        chk("rst_fwd_reg", 32'(bus.fwd_reg), 32'd0);
        chk("rst_fwd_data", 32'(bus.fwd_data), 32'd0);
        #10 RST = 1'b0;

        // ALU result written to r3
        drive(1'b1, 1'b1, 1'b0, 4'd3, 16'h1234, 16'h9999, 1'b0, 1'b0);
        chk("alu_en", 32'(bus.EN_WRITE_REG), 32'd0);
        idle();
        chk("heap_r3", 32'(heap[3]), 32'h1234);

        // Load data selected for r5
        drive(1'b1, 1'b1, 1'b1, 4'd5, 16'h0001, 16'hBEEF, 1'b0, 1'b0);
        chk("load_w_data", 32'(bus.w_data), 32'hBEEF);
        idle();
        chk("heap_r5", 32'(heap[5]), 32'hBEEF);

        // Stall: one write, then held with forwarding still valid
        drive(1'b1, 1'b1, 1'b0, 4'd7, 16'h00AA, 16'h0, 1'b0, 1'b0);
        chk("stall_first_en", 32'(bus.EN_WRITE_REG), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'd2, 16'hDEAD, 16'h0, 1'b1, 1'b0);
            chk("stall_held_en", 32'(bus.EN_WRITE_REG), 32'd1);
            chk("stall_held_fwd", 32'(bus.fwd_valid), 32'd1);
        end
        idle();
        chk("heap_r7", 32'(heap[7]), 32'h00AA);
        chk("heap_r2_untouched", 32'(heap[2]), 32'h0);

        // Flush together with stall kills the instruction
        drive(1'b1, 1'b1, 1'b0, 4'd8, 16'h0808, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 4'd9, 16'h0909, 16'h0, 1'b1, 1'b1);
        chk("flush_en", 32'(bus.EN_WRITE_REG), 32'd1);
        chk("flush_fwd", 32'(bus.fwd_valid), 32'd0);
        idle();

        // Write to r0: suppressed only where protection is enabled
        drive(1'b1, 1'b1, 1'b0, 4'd0, 16'hFFFF, 16'h0, 1'b0, 1'b0);
        chk("r0_prot_en", 32'(bus.EN_WRITE_REG), 32'd1);
        chk("r0_noprot_en", 32'(bus0.EN_WRITE_REG), 32'd0);
        chk("r0_noprot_fwd", 32'(bus0.fwd_valid), 32'd1);
        idle();
        chk("heap_r0_prot", 32'(heap[0]), 32'h0);
        chk("heap0_r0", 32'(heap0[0]), 32'hFFFF);

        // Back-to-back writes to the same register
        drive(1'b1, 1'b1, 1'b0, 4'd4, 16'h1111, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 4'd4, 16'h0, 16'h2222, 1'b0, 1'b0);
        idle();
        chk("heap_r4_last", 32'(heap[4]), 32'h2222);

        // Invalid / non-writing instructions
        drive(1'b0, 1'b1, 1'b0, 4'd6, 16'h6666, 16'h0, 1'b0, 1'b0);
        chk("inv_fwd", 32'(bus.fwd_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 4'd6, 16'h6666, 16'h0, 1'b0, 1'b0);
        chk("norw_en", 32'(bus.EN_WRITE_REG), 32'd1);
        idle();
        chk("heap_r6", 32'(heap[6]), 32'h0);

        // Reset asserted mid-cycle while a write is pending
        drive(1'b1, 1'b1, 1'b0, 4'd9, 16'h5555, 16'h0, 1'b0, 1'b0);
        idle();
        drive(1'b1, 1'b1, 1'b0, 4'd9, 16'hAAAA, 16'h0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #1 RST = 1'b1;
        #1;
        chk("rst_mid_en", 32'(bus.EN_WRITE_REG), 32'd1);
        chk("rst_mid_fwd", 32'(bus.fwd_valid), 32'd0);
        chk("rst_mid_w_data", 32'(bus.w_data), 32'd0);
        exp_q.delete();
        held_writer = 1'b0;
        writes_seen = 0;
        @(posedge CLK);
        #2 RST = 1'b0;
        chk("heap_r9_kept", 32'(heap[9]), 32'h5555);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
        end
        idle();
        idle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
